adc_capture: RTL and testbench
==============================

Name: adc_capture

Overview:
- Receive side of the ADC interface: the ADC driver block produces adc_clk and trigger, and this block consumes them.
- Samples the 14-bit ADC output bus on each adc_clk rising edge.
- Discards the converter's pipeline-latency samples, captures a fixed-length burst and buffers it in a small FIFO.
- Presents the buffered samples on a valid/ready stream to downstream processing.

Parameters:
DW, 14, ADC sample width
NSAMP, 32, samples per burst (>=1)
PIPE_LAT, 3, ADC pipeline latency in adc_clk periods; these leading samples are discarded
FIFO_DEPTH, 16, buffer depth (power of 2, >=2)
TWOS, 1, 1 = convert offset-binary to two's complement (invert MSB); 0 = pass through

Ports:
clk  in  1  system clock; adc_clk is generated synchronously in this domain
rst  in  1  synchronous, active-low reset
en  in  1  capture enable
trigger  in  1  start-of-burst pulse from the ADC driver
adc_clk  in  1  ADC sample clock, a divided copy of clk
adc_data  in  DW  parallel ADC output, stable around adc_clk rising edge
m_data  out  DW  head-of-FIFO sample
m_valid  out  1  FIFO not empty
m_ready  in  1  downstream accept; pop when m_valid&m_ready
busy  out  1  high in FLUSH or CAPTURE
done  out  1  one-cycle pulse at burst completion
overflow  out  1  sticky: a sample was dropped because the FIFO was full
count  out  clog2(NSAMP+1)  capture strobes taken in current burst

Behaviour:
- Reset: rst low at a clk edge clears all state. FSM=IDLE, FIFO empty; m_valid, busy, done, overflow, count all 0; m_data 0.
- Strobe: adc_clk_q registered each cycle; stb = adc_clk & ~adc_clk_q. adc_data is sampled in the stb cycle.
- FSM states IDLE, FLUSH, CAPTURE, DONE.
- IDLE:
  - trigger&en moves to FLUSH, or straight to CAPTURE if PIPE_LAT=0.
  - On that transition: flush counter=0, count=0, overflow=0.
- FLUSH:
  - Each stb increments the flush counter; the sample is not stored.
  - After PIPE_LAT strobes, go to CAPTURE.
  - A stb coinciding with the transition is consumed by FLUSH.
- CAPTURE:
  - Each stb increments count and pushes the converted sample.
  - When count reaches NSAMP, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Trigger while busy or in DONE: ignored.
- en low in FLUSH or CAPTURE:
  - Abort to IDLE next edge; no done pulse.
  - FIFO contents and count are kept.
- Push rules:
  - A push is accepted if the FIFO is not full, or a pop occurs in the same cycle.
  - Otherwise the sample is dropped, overflow is set, and count still increments.
- FIFO behaviour:
  - First-word fall-through.
  - A sample pushed at edge k is visible on m_data/m_valid in cycle k+1.
  - Pop on empty: no effect. Pointers wrap modulo FIFO_DEPTH.
  - The occupancy counter resolves simultaneous push and pop correctly.
- Conversion:
  - TWOS=1: m_data = {~s[DW-1], s[DW-2:0]}.
  - TWOS=0: m_data = s.
- Reset mid-burst: same as power-on reset; FIFO is flushed.

Decomposition:
- Package adc_pkg: ADC_DW=14, FSM state enumeration (IDLE, FLUSH, CAPTURE, DONE), to_twos conversion function.
- Sub-module adc_capture_fifo: parameters DW and DEPTH; ports push/din/full, pop/dout/empty; registered pointers and occupancy.
- Strobe detect, FSM, counters and conversion stay in the top level.

Test Plan:
- Reset mid-burst: assert rst low for 2 clk during CAPTURE -> next cycle busy=0, m_valid=0, count=0, overflow=0, done never pulses.
- Basic burst: NSAMP=4, PIPE_LAT=3, adc_clk period 4 clk, adc_data=0x2000+k at strobe k (k from 0), m_ready=1.
  - m_data sequence is 0x0003, 0x0004, 0x0005, 0x0006; the first three strobes are discarded.
  - done pulses exactly once, one cycle after the 7th strobe; count=4.
- Overflow: NSAMP=20, PIPE_LAT=0, m_ready=0 -> FIFO holds 16 samples, overflow=1 from the 17th strobe, count=20, done pulses. Draining then yields exactly the first 16 samples.
- Full with simultaneous pop: FIFO full, m_ready=1 in a strobe cycle -> sample accepted, overflow stays 0, occupancy stays 16.
- Control edges:
  - trigger pulsed during CAPTURE -> ignored; burst length unchanged.
  - en dropped after 2 captured samples -> IDLE next cycle, no done, 2 samples remain readable.
- Conversion with TWOS=1, PIPE_LAT=0: adc_data 0x0000 -> 0x2000, 0x3FFF -> 0x1FFF, 0x2000 -> 0x0000. TWOS=0: values pass through unchanged.

Source files
------------

// File: rtl/adc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adc_pkg
// Brief    : Shared types and helpers for the ADC capture path: default
//            sample width, capture FSM state encoding and the offset-binary
//            to two's-complement conversion.
// Revision : 1.0 - initial release
// ============================================================================
package adc_pkg;

  localparam int ADC_DW = 14;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FLUSH   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } adc_state_t;

  // Offset-binary to two's complement is just an MSB inversion
  function automatic logic [ADC_DW-1:0] to_twos(input logic [ADC_DW-1:0] s);
    return {~s[ADC_DW-1], s[ADC_DW-2:0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_capture_fifo.sv
`default_nettype none
// ============================================================================
// Module   : adc_capture_fifo
// Brief    : First-word fall-through sample buffer. A push while full is
//            accepted only when a pop happens in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module adc_capture_fifo
  import adc_pkg::*;
#(
  parameter int DW    = ADC_DW,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  output logic          full,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          empty
);

  localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_OW = $clog2(DEPTH + 1);

  logic [DW-1:0]   r_mem [DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_OW-1:0] r_occ;
  logic            w_do_pop;
  logic            w_do_push;

  assign empty     = (r_occ == '0);
  assign full      = (r_occ == c_OW'(DEPTH));
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);
  // Drive zero when empty so the output bus is defined right after reset
  assign dout      = empty ? '0 : r_mem[r_rd_ptr];

  // Storage array; contents need no reset because occupancy guards reads
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally (power-of-two depth); occupancy nets push vs pop
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/adc_capture.sv
`default_nettype none
// ============================================================================
// Module   : adc_capture
// Brief    : ADC receive path. Detects adc_clk rising edges in the clk
//            domain, discards pipeline-latency samples, captures a fixed
//            burst into a FWFT buffer and streams it out on valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module adc_capture
  import adc_pkg::*;
#(
  parameter int DW         = ADC_DW,
  parameter int NSAMP      = 32,
  parameter int PIPE_LAT   = 3,
  parameter int FIFO_DEPTH = 16,
  parameter int TWOS       = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           trigger,
  input  logic                           adc_clk,
  input  logic [DW-1:0]                  adc_data,
  output logic [DW-1:0]                  m_data,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic                           busy,
  output logic                           done,
  output logic                           overflow,
  output logic [$clog2(NSAMP+1)-1:0]     count
);

  localparam int c_CW = $clog2(NSAMP + 1);
  localparam int c_FW = (PIPE_LAT < 1) ? 1 : $clog2(PIPE_LAT + 1);
  localparam logic [c_CW-1:0] c_CNT_LAST   = c_CW'(NSAMP - 1);
  localparam logic [c_FW-1:0] c_FLUSH_LAST = c_FW'((PIPE_LAT > 0) ? (PIPE_LAT - 1) : 0);

  adc_state_t      r_state;
  adc_state_t      w_next;
  logic            r_adc_clk_q;
  logic            w_stb;
  logic [c_FW-1:0] r_flush_cnt;
  logic [c_CW-1:0] r_count;
  logic            r_overflow;
  logic            w_start;
  logic            w_flush_inc;
  logic            w_cap;
  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic [DW-1:0]   w_conv;

  // Delay adc_clk by one clk so its rising edge yields a single-cycle strobe
  always_ff @(posedge clk) begin
    if (!rst) r_adc_clk_q <= 1'b0;
    else      r_adc_clk_q <= adc_clk;
  end

  assign w_stb = adc_clk & ~r_adc_clk_q;
  assign w_pop = m_ready & ~w_empty;

  if (TWOS != 0) begin : g_twos
    if (DW == ADC_DW) begin : g_pkg
      assign w_conv = to_twos(adc_data);
    end else begin : g_generic
      assign w_conv = {~adc_data[DW-1], adc_data[DW-2:0]};
    end
  end else begin : g_pass
    assign w_conv = adc_data;
  end

  // Capture FSM state register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Next-state and per-cycle control; dropping en aborts without a done pulse
  always_comb begin
    w_next      = r_state;
    w_start     = 1'b0;
    w_flush_inc = 1'b0;
    w_cap       = 1'b0;
    case (r_state)
      IDLE: begin
        if (trigger && en) begin
          w_start = 1'b1;
          w_next  = (PIPE_LAT == 0) ? CAPTURE : FLUSH;
        end
      end
      FLUSH: begin
        if (!en) begin
          w_next = IDLE;
        end else if (w_stb) begin
          w_flush_inc = 1'b1;
          if (r_flush_cnt == c_FLUSH_LAST) w_next = CAPTURE;
        end
      end
      CAPTURE: begin
        if (!en) begin
          w_next = IDLE;
        end else if (w_stb) begin
          w_cap = 1'b1;
          if (r_count == c_CNT_LAST) w_next = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Burst counters and sticky overflow; a dropped sample still counts
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_flush_cnt <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
    end else if (w_start) begin
      r_flush_cnt <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_flush_inc) r_flush_cnt <= r_flush_cnt + 1'b1;
      if (w_cap)       r_count     <= r_count + 1'b1;
      if (w_cap && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  adc_capture_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_cap),
    .din   (w_conv),
    .full  (w_full),
    .pop   (m_ready),
    .dout  (m_data),
    .empty (w_empty)
  );

  assign m_valid  = ~w_empty;
  assign busy     = (r_state == FLUSH) || (r_state == CAPTURE);
  assign done     = (r_state == DONE);
  assign overflow = r_overflow;
  assign count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_adc_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_capture
// Brief    : Self-checking bench for adc_capture. Three parameterisations
//            share one stimulus; sel picks which one a scenario observes.
//            Expected samples are queued as strobes are driven and popped
//            as the selected instance hands them out.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_capture;

  logic        clk = 1'b0;
  logic        rst, en, trigger, adc_clk, m_ready;
  logic [13:0] adc_data;

  logic [13:0] md [3];
  logic [2:0]  vld, bsy, dn, ovf;
  logic [2:0]  cnt0, cnt2;
  logic [4:0]  cnt1;

  int          n_total = 0;
  int          n_pass  = 0;
  int          n_done  = 0;
  int          sel     = 0;
  logic [13:0] exp_q [$];
  logic [13:0] exp_v;

  always #5 clk = ~clk;

  // A: NSAMP=4 PIPE_LAT=3 TWOS=1
  adc_capture #(.DW(14), .NSAMP(4), .PIPE_LAT(3), .FIFO_DEPTH(16), .TWOS(1)) u_a (
    .clk(clk), .rst(rst), .en(en), .trigger(trigger), .adc_clk(adc_clk),
    .adc_data(adc_data), .m_data(md[0]), .m_valid(vld[0]), .m_ready(m_ready),
    .busy(bsy[0]), .done(dn[0]), .overflow(ovf[0]), .count(cnt0));
  // B: NSAMP=20 PIPE_LAT=0 TWOS=1
  adc_capture #(.DW(14), .NSAMP(20), .PIPE_LAT(0), .FIFO_DEPTH(16), .TWOS(1)) u_b (
    .clk(clk), .rst(rst), .en(en), .trigger(trigger), .adc_clk(adc_clk),
    .adc_data(adc_data), .m_data(md[1]), .m_valid(vld[1]), .m_ready(m_ready),
    .busy(bsy[1]), .done(dn[1]), .overflow(ovf[1]), .count(cnt1));
  // C: NSAMP=4 PIPE_LAT=0 TWOS=0
  adc_capture #(.DW(14), .NSAMP(4), .PIPE_LAT(0), .FIFO_DEPTH(16), .TWOS(0)) u_c (
    .clk(clk), .rst(rst), .en(en), .trigger(trigger), .adc_clk(adc_clk),
    .adc_data(adc_data), .m_data(md[2]), .m_valid(vld[2]), .m_ready(m_ready),
    .busy(bsy[2]), .done(dn[2]), .overflow(ovf[2]), .count(cnt2));

  function automatic int cnt_of(input int s);
    if (s == 0) return int'(cnt0);
    if (s == 1) return int'(cnt1);
    return int'(cnt2);
  endfunction

  // One clk cycle: observe at negedge (scoreboard pop), return at posedge+1
  task automatic step();
    @(negedge clk);
    if (dn[sel]) n_done++;
    if (rst && vld[sel] && m_ready) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL stream_extra: got %h expected no sample", md[sel]);
      end else begin
        exp_v = exp_q.pop_front();
        if (md[sel] !== exp_v)
          $display("FAIL stream_data: got %h expected %h", md[sel], exp_v);
        else
          n_pass++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // One adc_clk period of 4 clk; the strobe lands on the first edge
  task automatic adc_period(input logic [13:0] d);
    adc_clk  = 1'b1;
    adc_data = d;
    step();
    step();
    adc_clk = 1'b0;
    step();
    step();
  endtask

  task automatic reset_dut();
    rst = 1'b0; en = 1'b0; trigger = 1'b0; adc_clk = 1'b0; m_ready = 1'b0;
    adc_data = '0;
    step();
    step();
    rst = 1'b1;
    exp_q.delete();
    n_done = 0;
  endtask

  task automatic start_burst(input logic rdy);
    en = 1'b1; m_ready = rdy; trigger = 1'b1;
    step();
    trigger = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (bsy[i] !== 1'b0 || vld[i] !== 1'b0 || dn[i] !== 1'b0 || ovf[i] !== 1'b0)
        $display("FAIL reset_flags[%0d]: got b%0b v%0b d%0b o%0b expected all 0",
                 i, bsy[i], vld[i], dn[i], ovf[i]);
      else n_pass++;
      n_total++;
      if (md[i] !== 14'h0000 || cnt_of(i) != 0)
        $display("FAIL reset_data[%0d]: got data %h count %0d expected 0/0", i, md[i], cnt_of(i));
      else n_pass++;
    end
  endtask

  task automatic test_basic_burst();
    sel = 0;
    reset_dut();
    start_burst(1'b1);
    n_total++;
    if (bsy[0] !== 1'b1) $display("FAIL basic_busy: got %0b expected 1", bsy[0]);
    else n_pass++;
    for (int k = 0; k < 6; k++) begin
      if (k >= 3) exp_q.push_back(14'(k));
      adc_period(14'h2000 + 14'(k));
    end
    exp_q.push_back(14'h0006);
    adc_clk = 1'b1; adc_data = 14'h2006;
    step();
    n_total++;
    if (dn[0] !== 1'b1 || cnt0 !== 3'd4)
      $display("FAIL basic_done: got done %0b count %0d expected 1/4", dn[0], cnt0);
    else n_pass++;
    step();
    n_total++;
    if (dn[0] !== 1'b0 || bsy[0] !== 1'b0)
      $display("FAIL basic_after_done: got done %0b busy %0b expected 0/0", dn[0], bsy[0]);
    else n_pass++;
    adc_clk = 1'b0;
    for (int i = 0; i < 6; i++) step();
    n_total++;
    if (n_done != 1 || exp_q.size() != 0)
      $display("FAIL basic_pulses: got done %0d left %0d expected 1/0", n_done, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_overflow();
    sel = 1;
    reset_dut();
    start_burst(1'b0);
    for (int k = 0; k < 20; k++) begin
      if (k < 16) exp_q.push_back(14'h2100 + 14'(k));
      adc_period(14'h0100 + 14'(k));
      if (k == 15) begin
        n_total++;
        if (ovf[1] !== 1'b0 || vld[1] !== 1'b1)
          $display("FAIL ovf_at16: got ovf %0b valid %0b expected 0/1", ovf[1], vld[1]);
        else n_pass++;
      end
      if (k == 16) begin
        n_total++;
        if (ovf[1] !== 1'b1) $display("FAIL ovf_at17: got %0b expected 1", ovf[1]);
        else n_pass++;
      end
    end
    n_total++;
    if (cnt1 !== 5'd20 || n_done != 1 || ovf[1] !== 1'b1 || bsy[1] !== 1'b0)
      $display("FAIL ovf_end: got count %0d done %0d ovf %0b busy %0b expected 20/1/1/0",
               cnt1, n_done, ovf[1], bsy[1]);
    else n_pass++;
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) step();
    n_total++;
    if (exp_q.size() != 0 || vld[1] !== 1'b0)
      $display("FAIL ovf_drain: got left %0d valid %0b expected 0/0", exp_q.size(), vld[1]);
    else n_pass++;
  endtask

  task automatic test_full_pop();
    sel = 1;
    reset_dut();
    start_burst(1'b0);
    for (int k = 0; k < 16; k++) begin
      exp_q.push_back(14'h2100 + 14'(k));
      adc_period(14'h0100 + 14'(k));
    end
    exp_q.push_back(14'h2155);
    adc_clk = 1'b1; adc_data = 14'h0155; m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    n_total++;
    if (ovf[1] !== 1'b0) $display("FAIL fullpop_ovf: got %0b expected 0", ovf[1]);
    else n_pass++;
    step();
    adc_clk = 1'b0;
    step();
    step();
    // Occupancy must still be 16, so the next strobe without a pop is dropped
    adc_period(14'h0166);
    n_total++;
    if (ovf[1] !== 1'b1) $display("FAIL fullpop_still_full: got %0b expected 1", ovf[1]);
    else n_pass++;
    en = 1'b0;
    step();
    n_total++;
    if (bsy[1] !== 1'b0 || n_done != 0)
      $display("FAIL fullpop_abort: got busy %0b done %0d expected 0/0", bsy[1], n_done);
    else n_pass++;
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) step();
    n_total++;
    if (exp_q.size() != 0 || vld[1] !== 1'b0)
      $display("FAIL fullpop_drain: got left %0d valid %0b expected 0/0", exp_q.size(), vld[1]);
    else n_pass++;
  endtask

  task automatic test_control();
    sel = 0;
    reset_dut();
    start_burst(1'b1);
    for (int k = 0; k < 3; k++) adc_period(14'h2010 + 14'(k));
    exp_q.push_back(14'h0013);
    adc_period(14'h2013);
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    for (int k = 4; k < 7; k++) begin
      exp_q.push_back(14'h0010 + 14'(k));
      adc_period(14'h2010 + 14'(k));
    end
    for (int i = 0; i < 4; i++) step();
    n_total++;
    if (n_done != 1 || cnt0 !== 3'd4 || exp_q.size() != 0 || bsy[0] !== 1'b0)
      $display("FAIL trig_ignored: got done %0d count %0d left %0d busy %0b expected 1/4/0/0",
               n_done, cnt0, exp_q.size(), bsy[0]);
    else n_pass++;

    reset_dut();
    start_burst(1'b0);
    for (int k = 0; k < 3; k++) adc_period(14'h2020 + 14'(k));
    exp_q.push_back(14'h0020);
    adc_period(14'h2020);
    exp_q.push_back(14'h0021);
    adc_period(14'h2021);
    en = 1'b0;
    step();
    n_total++;
    if (bsy[0] !== 1'b0 || cnt0 !== 3'd2 || vld[0] !== 1'b1)
      $display("FAIL en_abort: got busy %0b count %0d valid %0b expected 0/2/1",
               bsy[0], cnt0, vld[0]);
    else n_pass++;
    step();
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    n_total++;
    if (n_done != 0 || exp_q.size() != 0 || vld[0] !== 1'b0)
      $display("FAIL en_abort_drain: got done %0d left %0d valid %0b expected 0/0/0",
               n_done, exp_q.size(), vld[0]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    sel = 0;
    reset_dut();
    start_burst(1'b1);
    for (int k = 0; k < 3; k++) adc_period(14'h2030 + 14'(k));
    exp_q.push_back(14'h0033);
    adc_period(14'h2033);
    adc_clk = 1'b1; adc_data = 14'h2034; m_ready = 1'b0;
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    exp_q.delete();
    n_total++;
    if (bsy[0] !== 1'b0 || vld[0] !== 1'b0 || cnt0 !== 3'd0 || ovf[0] !== 1'b0)
      $display("FAIL reset_mid: got busy %0b valid %0b count %0d ovf %0b expected 0/0/0/0",
               bsy[0], vld[0], cnt0, ovf[0]);
    else n_pass++;
    adc_clk = 1'b0;
    for (int i = 0; i < 6; i++) step();
    n_total++;
    if (n_done != 0 || bsy[0] !== 1'b0)
      $display("FAIL reset_mid_quiet: got done %0d busy %0b expected 0/0", n_done, bsy[0]);
    else n_pass++;
  endtask

  task automatic test_conversion();
    sel = 1;
    reset_dut();
    start_burst(1'b1);
    exp_q.push_back(14'h2000); adc_period(14'h0000);
    exp_q.push_back(14'h1FFF); adc_period(14'h3FFF);
    exp_q.push_back(14'h0000); adc_period(14'h2000);
    en = 1'b0;
    step();
    step();
    n_total++;
    if (exp_q.size() != 0) $display("FAIL twos_left: got %0d expected 0", exp_q.size());
    else n_pass++;

    sel = 2;
    reset_dut();
    start_burst(1'b1);
    exp_q.push_back(14'h0000); adc_period(14'h0000);
    exp_q.push_back(14'h3FFF); adc_period(14'h3FFF);
    exp_q.push_back(14'h2000); adc_period(14'h2000);
    exp_q.push_back(14'h1234); adc_period(14'h1234);
    step();
    n_total++;
    if (exp_q.size() != 0 || n_done != 1 || cnt2 !== 3'd4)
      $display("FAIL pass_end: got left %0d done %0d count %0d expected 0/1/4",
               exp_q.size(), n_done, cnt2);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; trigger = 1'b0; adc_clk = 1'b0; m_ready = 1'b0;
    adc_data = '0;
    test_reset();
    test_basic_burst();
    test_overflow();
    test_full_pop();
    test_control();
    test_reset_mid();
    test_conversion();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
